// File: rtl/ps2_dual_debouncer_if.sv
// Pin bundle between the raw PS/2 lines and the debouncer.
// master drives the raw keyboard lines; slave is the debouncer side.
interface ps2_dual_debouncer_if;
    logic In0;
    logic In1;
    logic Out0;
    logic Out1;

    modport master (output In0, output In1, input Out0, input Out1);
    modport slave  (input In0, input In1, output Out0, output Out1);
endinterface

// File: rtl/ps2_dual_debouncer.sv
// Two independent channels of 2-flop synchronizer plus stability-count
// debouncer for the PS/2 keyboard clock (In0) and data (In1) lines.
module ps2_dual_debouncer #(
    parameter int   STABLE_CYCLES = 19,
    parameter int   CNT_W         = 5,
    parameter logic RESET_LEVEL   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    ps2_dual_debouncer_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [1:0]       w_in;
    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_out;
    logic [CNT_W-1:0] r_cnt [2];

    assign w_in = {bus.In1, bus.In0};

    // A channel's count only advances while s2 disagrees with out; any
    // single agreeing cycle clears it, so short glitches never qualify.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1  <= {2{RESET_LEVEL}};
            r_s2  <= {2{RESET_LEVEL}};
            r_out <= {2{RESET_LEVEL}};
            for (int ch = 0; ch < 2; ch++) begin
                r_cnt[ch] <= '0;
            end
        end else begin
            r_s1 <= w_in;
            r_s2 <= r_s1;
            for (int ch = 0; ch < 2; ch++) begin
                if (r_s2[ch] == r_out[ch]) begin
                    r_cnt[ch] <= '0;
                end else if (r_cnt[ch] == LAST) begin
                    r_out[ch] <= r_s2[ch];
                    r_cnt[ch] <= '0;
                end else begin
                    r_cnt[ch] <= r_cnt[ch] + 1'b1;
                end
            end
        end
    end

    assign bus.Out0 = r_out[0];
    assign bus.Out1 = r_out[1];

endmodule

// File: tb/tb_ps2_dual_debouncer.sv
// Directed bench for ps2_dual_debouncer: a pulse table plus hand-written
// sequences for counter restart, channel independence and async reset.
module tb_ps2_dual_debouncer;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    ps2_dual_debouncer_if bus ();

    ps2_dual_debouncer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ch;
        int    len;        // edges the input is held low
        int    exp_first;  // edge index of first low Out, -1 if none
        int    exp_lows;   // number of edges Out is low
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic set_in(input int ch, input logic v);
        if (ch == 0) bus.In0 = v;
        else         bus.In1 = v;
    endtask

    function automatic logic get_out(input int ch);
        return (ch == 0) ? bus.Out0 : bus.Out1;
    endfunction

    task automatic run_vec(input vec_t v);
        int first;
        int lows;
        int other_lows;
        first      = -1;
        lows       = 0;
        other_lows = 0;
        set_in(v.ch, 1'b0);
        for (int e = 0; e < 80; e++) begin
            tick();
            if (get_out(v.ch) == 1'b0) begin
                lows++;
                if (first < 0) first = e;
            end
            if (get_out(1 - v.ch) == 1'b0) other_lows++;
            if (e == v.len - 1) set_in(v.ch, 1'b1);
        end
        check({v.name, "_first"}, first, v.exp_first);
        check({v.name, "_lows"}, lows, v.exp_lows);
        check({v.name, "_other"}, other_lows, 0);
    endtask

    initial begin
        int lows0;
        int lows1;
        int first;
        logic lvl;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{"ch1_18",  1, 18, -1,  0};
        vecs[1] = '{"ch1_19",  1, 19, 20, 19};
        vecs[2] = '{"ch0_19",  0, 19, 20, 19};
        vecs[3] = '{"ch0_1",   0,  1, -1,  0};
        vecs[4] = '{"ch0_18",  0, 18, -1,  0};
        vecs[5] = '{"ch1_25",  1, 25, 20, 25};
        vecs[6] = '{"ch0_40",  0, 40, 20, 40};

        // Reset held with inputs low: outputs stay at the idle level.
        rst    = 1'b1;
        bus.In0 = 1'b0;
        bus.In1 = 1'b0;
        #2;
        check("reset_out0_async", int'(bus.Out0), 1);
        check("reset_out1_async", int'(bus.Out1), 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("reset_out0", int'(bus.Out0), 1);
            check("reset_out1", int'(bus.Out1), 1);
        end
        bus.In0 = 1'b1;
        bus.In1 = 1'b1;
        rst     = 1'b0;
        lows0 = 0;
        lows1 = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!bus.Out0) lows0++;
            if (!bus.Out1) lows1++;
        end
        check("idle_out0_lows", lows0, 0);
        check("idle_out1_lows", lows1, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Counter restart: 15 low, 1 high, then low; the final fall is
        // sampled at edge 16 so Out0 falls at edge 36.
        first = -1;
        bus.In0 = 1'b0;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (!bus.Out0 && first < 0) first = e;
            if (e == 14) bus.In0 = 1'b1;
            if (e == 15) bus.In0 = 1'b0;
        end
        check("restart_first", first, 36);
        bus.In0 = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("restart_recover", int'(bus.Out0), 1);

        // Independence: In0 changes at edges 0/100/200, In1 bounces each cycle.
        lows1 = 0;
        lvl   = 1'b1;
        bus.In0 = 1'b0;
        bus.In1 = 1'b0;
        for (int e = 0; e < 300; e++) begin
            tick();
            if (!bus.Out1) lows1++;
            if (e % 100 == 19) check("indep_out0_hold", int'(bus.Out0), int'(lvl));
            if (e % 100 == 20) begin
                lvl = ~lvl;
                check("indep_out0_move", int'(bus.Out0), int'(lvl));
            end
            bus.In1 = ~bus.In1;
            if (e % 100 == 99) bus.In0 = ~bus.In0;
        end
        check("indep_out1_lows", lows1, 0);
        bus.In0 = 1'b1;
        bus.In1 = 1'b1;
        for (int i = 0; i < 40; i++) tick();

        // Async reset in the middle of a pending rise on channel 0.
        bus.In0 = 1'b0;
        for (int i = 0; i < 25; i++) tick();
        check("areset_pre_low", int'(bus.Out0), 0);
        bus.In0 = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("areset_pending", int'(bus.Out0), 0);
        #3;
        rst = 1'b1;
        #1;
        check("areset_immediate", int'(bus.Out0), 1);
        bus.In0 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int e = 0; e < 25; e++) begin
            tick();
            if (e == 19) check("areset_req_hold", int'(bus.Out0), 1);
            if (e == 20) check("areset_req_fall", int'(bus.Out0), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
